// File: rtl/txformat.sv
// Outbound message formatter for the vending-machine serial link.
// Emits "V<d>" / "C<ddd>" (+ optional CR LF) one byte at a time via the tx_dv / tx_active handshake.
module txformat #(
  parameter int CRLF_EN     = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vend,
  input  logic [2:0] vend_item,
  input  logic       credit_upd,
  input  logic [7:0] credit,
  input  logic       tx_active,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       msg_done
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_vend_pend, r_cred_pend;
  logic [2:0]     r_item;
  logic [7:0]     r_credit;
  logic           r_is_c;
  logic [7:0]     r_val;
  logic [2:0]     r_idx;
  logic [7:0]     r_byte;
  logic           r_msg_done;
  logic [CW-1:0]  r_cnt;

  logic           w_start, w_sel_c, w_advance, w_last, w_ack_to;
  logic [2:0]     w_last_idx;

  function automatic logic [7:0] f_byte(input logic is_c, input logic [7:0] val,
                                        input logic [2:0] idx);
    logic [7:0] h, t, u;
    h = val / 8'd100;
    t = (val / 8'd10) % 8'd10;
    u = val % 8'd10;
    f_byte = '0;
    if (!is_c) begin
      case (idx)
        3'd0:    f_byte = 8'h56;
        3'd1:    f_byte = 8'h30 + {5'd0, val[2:0]};
        3'd2:    f_byte = 8'h0D;
        3'd3:    f_byte = 8'h0A;
        default: f_byte = '0;
      endcase
    end else begin
      case (idx)
        3'd0:    f_byte = 8'h43;
        3'd1:    f_byte = 8'h30 + h;
        3'd2:    f_byte = 8'h30 + t;
        3'd3:    f_byte = 8'h30 + u;
        3'd4:    f_byte = 8'h0D;
        3'd5:    f_byte = 8'h0A;
        default: f_byte = '0;
      endcase
    end
  endfunction

  assign w_last_idx = r_is_c ? ((CRLF_EN != 0) ? 3'd5 : 3'd3)
                             : ((CRLF_EN != 0) ? 3'd3 : 3'd1);
  assign w_ack_to   = (r_cnt == CW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sel_c     = !r_vend_pend;
    w_advance   = 1'b0;
    w_last      = (r_idx == w_last_idx);
    case (r_state)
      S_IDLE:
        if ((r_vend_pend || r_cred_pend) && !tx_active) begin
          w_start     = 1'b1;
          w_state_nxt = S_SEND;
        end
      S_SEND:      w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:
        if (tx_active || w_ack_to) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE:
        if (!tx_active) begin
          w_advance   = 1'b1;
          w_state_nxt = w_last ? S_IDLE : S_SEND;
        end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // A new event in the same cycle its message starts stays pending for the next message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vend_pend <= 1'b0;
      r_cred_pend <= 1'b0;
      r_item      <= '0;
      r_credit    <= '0;
    end else begin
      if (vend) begin
        r_vend_pend <= 1'b1;
        r_item      <= vend_item;
      end else if (w_start && !w_sel_c) begin
        r_vend_pend <= 1'b0;
      end
      if (credit_upd) begin
        r_cred_pend <= 1'b1;
        r_credit    <= credit;
      end else if (w_start && w_sel_c) begin
        r_cred_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_c     <= 1'b0;
      r_val      <= '0;
      r_idx      <= '0;
      r_byte     <= '0;
      r_msg_done <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_msg_done <= w_advance && w_last;
      r_cnt      <= (r_state == S_WAIT_ACK) ? r_cnt + CW'(1) : '0;
      if (w_start) begin
        r_is_c <= w_sel_c;
        r_val  <= w_sel_c ? r_credit : {5'd0, r_item};
        r_idx  <= '0;
        r_byte <= w_sel_c ? 8'h43 : 8'h56;
      end else if (w_advance && !w_last) begin
        r_idx  <= r_idx + 3'd1;
        r_byte <= f_byte(r_is_c, r_val, r_idx + 3'd1);
      end
    end
  end

  assign tx_dv    = (r_state == S_SEND);
  assign tx_byte  = r_byte;
  assign busy     = (r_state != S_IDLE) || r_vend_pend || r_cred_pend;
  assign msg_done = r_msg_done;

endmodule
